// File: rtl/entrada_codigo.sv
// Keypad entry stage: collects up to six BCD digits, supports backspace, clear,
// inactivity timeout and a frozen confirm/hold phase for the downstream comparator.
module entrada_codigo #(
    parameter int TIMEOUT_CYC = 50000000,
    parameter int HOLD_CYC    = 100000000,
    parameter int CNT_W       = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] tecla,
    input  logic       tecla_valida,
    input  logic       apagar,
    input  logic       limpar,
    input  logic       confirmar,
    output logic [3:0] m0,
    output logic [3:0] m1,
    output logic [3:0] m2,
    output logic [3:0] m3,
    output logic [3:0] m4,
    output logic [3:0] m5,
    output logic [2:0] d,
    output logic       cheio,
    output logic       pronto,
    output logic       erro
);

    typedef enum logic [1:0] {
        ENTRADA  = 2'd0,
        CHEIO    = 2'd1,
        BLOQUEIO = 2'd2
    } state_t;

    localparam int                 NDIG      = 6;
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       m_q [NDIG];
    logic [3:0]       m_d [NDIG];
    logic [2:0]       ndig_q, ndig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             erro_q, erro_d;
    logic             cheio_q, pronto_q;
    logic             tv_prev_q, ap_prev_q, cf_prev_q;

    logic tv_ev, ap_ev, cf_ev;
    logic timeout_hit;

    assign tv_ev = tecla_valida & ~tv_prev_q;
    assign ap_ev = apagar       & ~ap_prev_q;
    assign cf_ev = confirmar    & ~cf_prev_q;

    // The shared counter only means "idle time" outside the hold phase.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (ndig_q != 3'd0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        ndig_d  = ndig_q;
        cnt_d   = cnt_q;
        erro_d  = 1'b0;

        case (state_q)
            BLOQUEIO: begin
                if (cnt_q == HOLD_LAST) begin
                    for (int i = 0; i < NDIG; i++) begin
                        m_d[i] = 4'd0;
                    end
                    ndig_d  = 3'd0;
                    cnt_d   = '0;
                    state_d = ENTRADA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                if (limpar || timeout_hit) begin
                    for (int i = 0; i < NDIG; i++) begin
                        m_d[i] = 4'd0;
                    end
                    ndig_d  = 3'd0;
                    cnt_d   = '0;
                    state_d = ENTRADA;
                end else if (ap_ev) begin
                    cnt_d = '0;
                    if (ndig_q != 3'd0) begin
                        for (int i = 0; i < NDIG; i++) begin
                            if (ndig_q == 3'(i + 1)) begin
                                m_d[i] = 4'd0;
                            end
                        end
                        ndig_d  = ndig_q - 3'd1;
                        state_d = ENTRADA;
                    end
                end else if (cf_ev) begin
                    cnt_d = '0;
                    if (state_q == CHEIO) begin
                        state_d = BLOQUEIO;
                    end else begin
                        erro_d = 1'b1;
                    end
                end else if (tv_ev) begin
                    cnt_d = '0;
                    if ((state_q == CHEIO) || (tecla > 4'd9)) begin
                        erro_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NDIG; i++) begin
                            if (ndig_q == 3'(i)) begin
                                m_d[i] = tecla;
                            end
                        end
                        ndig_d = ndig_q + 3'd1;
                        if (ndig_q == 3'd5) begin
                            state_d = CHEIO;
                        end
                    end
                end else if ((ndig_q != 3'd0) && (TIMEOUT_CYC != 0)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ENTRADA;
            ndig_q    <= 3'd0;
            cnt_q     <= '0;
            erro_q    <= 1'b0;
            cheio_q   <= 1'b0;
            pronto_q  <= 1'b0;
            tv_prev_q <= 1'b0;
            ap_prev_q <= 1'b0;
            cf_prev_q <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                m_q[i] <= 4'd0;
            end
        end else begin
            state_q   <= state_d;
            ndig_q    <= ndig_d;
            cnt_q     <= cnt_d;
            erro_q    <= erro_d;
            cheio_q   <= (state_d == CHEIO);
            pronto_q  <= (state_d == BLOQUEIO);
            tv_prev_q <= tecla_valida;
            ap_prev_q <= apagar;
            cf_prev_q <= confirmar;
            for (int i = 0; i < NDIG; i++) begin
                m_q[i] <= m_d[i];
            end
        end
    end

    assign m0     = m_q[0];
    assign m1     = m_q[1];
    assign m2     = m_q[2];
    assign m3     = m_q[3];
    assign m4     = m_q[4];
    assign m5     = m_q[5];
    assign d      = ndig_q;
    assign cheio  = cheio_q;
    assign pronto = pronto_q;
    assign erro   = erro_q;

endmodule

// File: tb/tb_entrada_codigo.sv
// Bench for entrada_codigo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_entrada_codigo;

    localparam int T_TO   = 8;
    localparam int T_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tecla = 4'd0;
    logic       tecla_valida = 1'b0;
    logic       apagar = 1'b0;
    logic       limpar = 1'b0;
    logic       confirmar = 1'b0;
    logic [3:0] m0, m1, m2, m3, m4, m5;
    logic [2:0] d;
    logic       cheio, pronto, erro;

    entrada_codigo #(
        .TIMEOUT_CYC(T_TO),
        .HOLD_CYC   (T_HOLD),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tecla       (tecla),
        .tecla_valida(tecla_valida),
        .apagar      (apagar),
        .limpar      (limpar),
        .confirmar   (confirmar),
        .m0(m0), .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5),
        .d           (d),
        .cheio       (cheio),
        .pronto      (pronto),
        .erro        (erro)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the entry is a queue of digits; the lock and idle
    // times are plain cycle tallies.
    int digs[$];
    bit blocked = 1'b0;
    int held = 0;
    int idle = 0;
    bit m_erro = 1'b0;
    bit p_tv = 1'b0, p_ap = 1'b0, p_cf = 1'b0;

    always @(posedge clk) begin
        bit e_tv, e_ap, e_cf;
        if (rst) begin
            digs.delete();
            blocked = 1'b0;
            held    = 0;
            idle    = 0;
            m_erro  = 1'b0;
            p_tv = 1'b0; p_ap = 1'b0; p_cf = 1'b0;
        end else begin
            e_tv = tecla_valida && !p_tv;
            e_ap = apagar && !p_ap;
            e_cf = confirmar && !p_cf;
            m_erro = 1'b0;
            if (blocked) begin
                held++;
                if (held == T_HOLD) begin
                    blocked = 1'b0;
                    digs.delete();
                end
            end else if (limpar) begin
                digs.delete();
                idle = 0;
            end else if (digs.size() > 0 && idle + 1 == T_TO) begin
                digs.delete();
                idle = 0;
            end else if (e_ap) begin
                idle = 0;
                if (digs.size() > 0) void'(digs.pop_back());
            end else if (e_cf) begin
                idle = 0;
                if (digs.size() == 6) begin
                    blocked = 1'b1;
                    held = 0;
                end else begin
                    m_erro = 1'b1;
                end
            end else if (e_tv) begin
                idle = 0;
                if (digs.size() < 6 && tecla <= 4'd9) digs.push_back(int'(tecla));
                else m_erro = 1'b1;
            end else if (digs.size() > 0) begin
                idle++;
            end
            p_tv = tecla_valida;
            p_ap = apagar;
            p_cf = confirmar;
        end
    end

    function automatic int exp_m(input int i);
        return (i < digs.size()) ? digs[i] : 0;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m0", int'(m0), exp_m(0));
            chk("m1", int'(m1), exp_m(1));
            chk("m2", int'(m2), exp_m(2));
            chk("m3", int'(m3), exp_m(3));
            chk("m4", int'(m4), exp_m(4));
            chk("m5", int'(m5), exp_m(5));
            chk("d", int'(d), digs.size());
            chk("cheio", int'(cheio), int'(!blocked && digs.size() == 6));
            chk("pronto", int'(pronto), int'(blocked));
            chk("erro", int'(erro), int'(m_erro));
        end
    end

    bit last_erro;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        tecla = k;
        tecla_valida = 1'b1;
        step();
        last_erro = erro;
        tecla_valida = 1'b0;
        step();
    endtask

    task automatic pulse_ap();
        apagar = 1'b1;
        step();
        last_erro = erro;
        apagar = 1'b0;
        step();
    endtask

    task automatic pulse_cf();
        confirmar = 1'b1;
        step();
        last_erro = erro;
        confirmar = 1'b0;
        step();
    endtask

    task automatic do_clear();
        limpar = 1'b1;
        step();
        limpar = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) press(4'(i + 1));
    endtask

    initial begin
        bit err_acc;
        int pr_cnt;

        // Reset
        step();
        cmp_en = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_d", int'(d), 0);
        chk("rst_pronto", int'(pronto), 0);
        chk("rst_cheio", int'(cheio), 0);
        chk("rst_m0", int'(m0), 0);
        $display("reset released");

        // Six digits 0,0,0,1,1,1
        err_acc = 1'b0;
        press(4'd0); err_acc |= last_erro;
        press(4'd0); err_acc |= last_erro;
        press(4'd0); err_acc |= last_erro;
        press(4'd1); err_acc |= last_erro;
        press(4'd1); err_acc |= last_erro;
        press(4'd1); err_acc |= last_erro;
        chk("seq_m2", int'(m2), 0);
        chk("seq_m3", int'(m3), 1);
        chk("seq_m5", int'(m5), 1);
        chk("seq_d", int'(d), 6);
        chk("seq_cheio", int'(cheio), 1);
        chk("seq_erro", int'(err_acc), 0);
        $display("entered 000111 d=%0d", d);

        // Key held high: one store; idle timeout still runs while it is held
        do_clear();
        tecla = 4'd5;
        tecla_valida = 1'b1;
        repeat (6) step();
        chk("hold_d", int'(d), 1);
        chk("hold_m0", int'(m0), 5);
        repeat (4) step();
        tecla_valida = 1'b0;
        step();
        chk("hold_to_d", int'(d), 0);
        $display("held key: one store then timeout, d=%0d", d);

        // Seventh digit rejected
        do_clear();
        fill(6);
        press(4'd3);
        chk("d7_erro", int'(last_erro), 1);
        chk("d7_erro_end", int'(erro), 0);
        chk("d7_d", int'(d), 6);
        chk("d7_m5", int'(m5), 6);
        $display("seventh digit rejected");

        // Non-BCD key
        do_clear();
        fill(2);
        press(4'hC);
        chk("bcd_erro", int'(last_erro), 1);
        chk("bcd_d", int'(d), 2);
        $display("non-BCD key rejected");

        // Backspace
        do_clear();
        press(4'd4); press(4'd7); press(4'd2);
        pulse_ap();
        chk("bs_d", int'(d), 2);
        chk("bs_m2", int'(m2), 0);
        chk("bs_m1", int'(m1), 7);
        pulse_ap(); pulse_ap(); pulse_ap();
        chk("bs_d0", int'(d), 0);
        pulse_ap();
        chk("bs_noop_d", int'(d), 0);
        chk("bs_noop_erro", int'(last_erro), 0);
        fill(2);
        tecla = 4'd9;
        tecla_valida = 1'b1;
        apagar = 1'b1;
        step();
        tecla_valida = 1'b0;
        apagar = 1'b0;
        step();
        chk("bs_sim_d", int'(d), 1);
        chk("bs_sim_m0", int'(m0), 1);
        chk("bs_sim_m1", int'(m1), 0);
        $display("backspace d=%0d", d);

        // Confirm and hold; clear and key presses ignored while held
        do_clear();
        fill(6);
        pr_cnt = 0;
        confirmar = 1'b1;
        step();
        pr_cnt += int'(pronto);
        chk("lock_d", int'(d), 6);
        chk("lock_cheio", int'(cheio), 0);
        confirmar = 1'b0;
        limpar = 1'b1;
        tecla = 4'd9;
        tecla_valida = 1'b1;
        step();
        pr_cnt += int'(pronto);
        chk("lock_frozen_d", int'(d), 6);
        chk("lock_frozen_m5", int'(m5), 6);
        limpar = 1'b0;
        tecla_valida = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            pr_cnt += int'(pronto);
        end
        chk("lock_pronto_len", pr_cnt, T_HOLD);
        chk("lock_end_d", int'(d), 0);
        chk("lock_end_m0", int'(m0), 0);
        $display("hold phase pronto cycles=%0d", pr_cnt);

        // Confirm at d=5
        do_clear();
        fill(5);
        pulse_cf();
        chk("cf5_erro", int'(last_erro), 1);
        chk("cf5_pronto", int'(pronto), 0);
        chk("cf5_d", int'(d), 5);
        $display("early confirm rejected");

        // Inactivity timeout
        do_clear();
        press(4'd1); press(4'd2);
        repeat (6) step();
        chk("to_before_d", int'(d), 2);
        step();
        chk("to_after_d", int'(d), 0);
        press(4'd1); press(4'd2);
        repeat (4) step();
        press(4'hF);
        chk("to_rst_erro", int'(last_erro), 1);
        repeat (6) step();
        chk("to_restart_d", int'(d), 2);
        step();
        chk("to_restart_clr", int'(d), 0);
        $display("timeout checked");

        // Reset during hold
        do_clear();
        fill(6);
        confirmar = 1'b1;
        step();
        confirmar = 1'b0;
        step();
        chk("rh_pronto_pre", int'(pronto), 1);
        rst = 1'b1;
        step();
        chk("rh_pronto", int'(pronto), 0);
        chk("rh_d", int'(d), 0);
        chk("rh_m0", int'(m0), 0);
        chk("rh_cheio", int'(cheio), 0);
        rst = 1'b0;
        $display("reset during hold");

        // Reset during entry with a key held through it
        fill(3);
        tecla = 4'd8;
        tecla_valida = 1'b1;
        rst = 1'b1;
        step();
        chk("re_d", int'(d), 0);
        chk("re_erro", int'(erro), 0);
        rst = 1'b0;
        step();
        chk("re_key_d", int'(d), 1);
        chk("re_key_m0", int'(m0), 8);
        step(); step();
        chk("re_once_d", int'(d), 1);
        tecla_valida = 1'b0;
        step();
        $display("reset during entry");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
